imem_responder: RTL and testbench

- Instruction-memory responder that serves fetch requests issued by the IF stage, which is the request initiator.
- Accepts word addresses on a valid/ready request channel and returns 32-bit instruction words in order, after a fixed read latency, on a valid/ready response channel.
- Holds the program in an internal word array, loaded through a write port by the testbench or boot logic.
- Sits between the IF stage and the program store inside the core top.

---
 rtl/imem_responder_pkg.sv | 13 +
 rtl/imem_responder_resp_fifo.sv | 63 ++++++
 rtl/imem_responder.sv | 126 ++++++++++++
 tb/tb_imem_responder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// Shared constants and the response bundle
// used by the instruction-memory responder.
package imem_responder_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSN_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            err;
  } resp_t;

endpackage

// File: rtl/imem_responder_resp_fifo.sv
// In-order response buffer with count,
// full/empty and a synchronous clear.
module imem_responder_resp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 33,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency, in-order instruction fetch
// responder with a credit-limited buffer.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int RESP_DEPTH  = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           io_req_valid,
  output logic                           io_req_ready,
  input  logic [XLEN-1:0]                io_req_addr,
  output logic                           io_resp_valid,
  input  logic                           io_resp_ready,
  output logic [XLEN-1:0]                io_resp_data,
  output logic                           io_resp_err,
  input  logic                           io_flush,
  input  logic                           io_load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] io_load_addr,
  input  logic [XLEN-1:0]                io_load_data
);

  localparam int AW     = $clog2(DEPTH_WORDS);
  localparam int CW     = $clog2(RESP_DEPTH) + 1;
  localparam int OW     = CW + 2;
  localparam int STAGES = LATENCY - 1;
  localparam int RW     = $bits(resp_t);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic          accept;
  logic [AW-1:0] idx;
  logic          bad;
  resp_t         rd;
  logic          push;
  resp_t         push_b;
  logic [OW-1:0] inflight;
  logic [OW-1:0] outstanding;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [RW-1:0] head_raw;
  resp_t         head;
  logic          pop;

  assign idx = io_req_addr[AW+1:2];
  assign bad = (io_req_addr[1:0] != 2'b00)
            || (64'(io_req_addr) >= 64'(DEPTH_WORDS) * 64'd4);

  // Read happens before the same-edge load write lands
  always_comb begin
    rd.err  = bad;
    rd.data = bad ? INSN_NOP : mem[idx];
  end

  always_ff @(posedge clock) begin
    if (io_load_en) mem[io_load_addr] <= io_load_data;
  end

  assign outstanding  = inflight + OW'(fifo_count);
  assign io_req_ready = reset & ~io_flush & ~fifo_full
                      & (outstanding < OW'(RESP_DEPTH));
  assign accept       = io_req_valid & io_req_ready;

  // The FIFO register is the last latency stage
  if (STAGES == 0) begin : g_direct
    assign push     = accept;
    assign push_b   = rd;
    assign inflight = '0;
  end else begin : g_delay
    logic [STAGES-1:0] dl_valid;
    resp_t             dl_data [STAGES];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        dl_valid <= '0;
      end else if (io_flush) begin
        dl_valid <= '0;
      end else begin
        dl_valid[0] <= accept;
        for (int i = 1; i < STAGES; i++)
          dl_valid[i] <= dl_valid[i-1];
      end
    end

    always_ff @(posedge clock) begin
      dl_data[0] <= rd;
      for (int i = 1; i < STAGES; i++)
        dl_data[i] <= dl_data[i-1];
    end

    always_comb begin
      inflight = '0;
      for (int i = 0; i < STAGES; i++)
        inflight = inflight + OW'(dl_valid[i]);
    end

    assign push   = dl_valid[STAGES-1];
    assign push_b = dl_data[STAGES-1];
  end

  imem_responder_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (RW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (io_flush),
    .push      (push),
    .push_data (push_b),
    .pop       (pop),
    .pop_data  (head_raw),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head          = resp_t'(head_raw);
  assign io_resp_valid = ~fifo_empty;
  assign pop           = io_resp_valid & io_resp_ready;
  assign io_resp_data  = io_resp_valid ? head.data : '0;
  assign io_resp_err   = io_resp_valid & head.err;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized and directed bench for the
// instruction-memory responder.
module tb_imem_responder;
  import imem_responder_pkg::*;

  localparam int DW  = 1024;
  localparam int LAT = 2;
  localparam int RD  = 4;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        flush;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [31:0] load_data;

  imem_responder #(
    .DEPTH_WORDS (DW),
    .LATENCY     (LAT),
    .RESP_DEPTH  (RD)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .io_req_valid  (req_valid),
    .io_req_ready  (req_ready),
    .io_req_addr   (req_addr),
    .io_resp_valid (resp_valid),
    .io_resp_ready (resp_ready),
    .io_resp_data  (resp_data),
    .io_resp_err   (resp_err),
    .io_flush      (flush),
    .io_load_en    (load_en),
    .io_load_addr  (load_addr),
    .io_load_data  (load_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          t;
    logic [31:0] d;
    logic        e;
  } ent_t;

  typedef struct {
    int          c;
    logic [31:0] d;
    logic        e;
  } obs_t;

  ent_t        q[$];
  obs_t        got[$];
  logic [31:0] mm [DW];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Reference: a queue of accepted requests,
  // each visible from accept cycle + LAT.
  bit   m_vis;
  bit   m_acc;
  ent_t m_e;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      q.delete();
    end else begin
      m_vis = q.size() > 0 && q[0].t <= cyc;
      m_acc = req_valid && !flush && q.size() < RD;
      if (m_acc) begin
        m_e.t = cyc + LAT;
        m_e.e = (req_addr % 4 != 0) || (req_addr >= 4 * DW);
        m_e.d = m_e.e ? 32'h13 : mm[req_addr[11:2]];
      end
      if (flush) begin
        q.delete();
      end else begin
        if (m_vis && resp_ready) void'(q.pop_front());
        if (m_acc) q.push_back(m_e);
      end
      if (load_en) mm[load_addr] = load_data;
      cyc++;
    end
  end

  bit ev;
  bit er;

  always @(negedge clock) begin
    if (!reset) begin
      check("rst_resp_valid", 32'(resp_valid), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_resp_err", 32'(resp_err), 0);
    end else begin
      ev = q.size() > 0 && q[0].t <= cyc;
      er = !flush && q.size() < RD;
      check("req_ready", 32'(req_ready), 32'(er));
      check("resp_valid", 32'(resp_valid), 32'(ev));
      if (ev) begin
        check("resp_data", resp_data, q[0].d);
        check("resp_err", 32'(resp_err), 32'(q[0].e));
      end
      if (resp_valid && resp_ready)
        got.push_back('{cyc, resp_data, resp_err});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_got(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("wait_resp", 32'(got.size() >= n), 1);
  endtask

  logic [31:0] pat [4];
  int          t0;
  int          acc;
  int          r;

  initial begin
    pat[0] = 32'h1111_1111;
    pat[1] = 32'h2222_2222;
    pat[2] = 32'h3333_3333;
    pat[3] = 32'h4444_4444;
    reset = 0; req_valid = 0; req_addr = 0;
    resp_ready = 0; flush = 0; load_en = 0;
    load_addr = 0; load_data = 0;
    repeat (3) tick();
    #1 check("reset_req_ready", 32'(req_ready), 0);
    check("reset_resp_valid", 32'(resp_valid), 0);
    reset = 1;
    #1 check("post_reset_ready", 32'(req_ready), 1);
    tick();

    for (int i = 0; i < DW; i++) begin
      load_en = 1;
      load_addr = 10'(i);
      load_data = $urandom;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      load_addr = 10'(i);
      load_data = pat[i];
      tick();
    end
    load_en = 0;

    // Back-to-back fetches, consumer always ready
    got.delete();
    resp_ready = 1;
    req_valid = 1;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'(i * 4);
      #1 check("t1_req_ready", 32'(req_ready), 1);
      tick();
    end
    req_valid = 0;
    wait_got(4, 12);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      check("t1_data", got[i].d, pat[i]);
      check("t1_err", 32'(got[i].e), 0);
      check("t1_cycle", 32'(got[i].c), 32'(t0 + 2 + i));
    end

    // Stalled consumer: credit limit
    got.delete();
    resp_ready = 0;
    req_valid = 1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_addr = 32'((i % 4) * 4);
      #1 if (req_ready) acc++;
      tick();
    end
    check("t2_accepted", 32'(acc), 4);
    check("t2_ready_low", 32'(req_ready), 0);
    req_valid = 0;
    resp_ready = 1;
    wait_got(4, 12);
    for (int i = 0; i < 4 && i < got.size(); i++)
      check("t2_data", got[i].d, pat[i]);

    // Misaligned and out-of-range
    got.delete();
    req_valid = 1;
    req_addr = 32'h6;
    tick();
    req_addr = 32'h1000;
    tick();
    req_valid = 0;
    wait_got(2, 12);
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      check("t3_nop", got[i].d, 32'h0000_0013);
      check("t3_err", 32'(got[i].e), 1);
    end

    // Flush with requests outstanding
    got.delete();
    resp_ready = 0;
    req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      req_addr = 32'(i * 4);
      tick();
    end
    req_valid = 0;
    tick();
    flush = 1;
    #1 check("t4_flush_ready", 32'(req_ready), 0);
    tick();
    flush = 0;
    resp_ready = 1;
    #1 check("t4_valid_gone", 32'(resp_valid), 0);
    repeat (5) tick();
    check("t4_no_stale", 32'(got.size()), 0);
    req_valid = 1;
    req_addr = 32'h4;
    t0 = cyc;
    tick();
    req_valid = 0;
    wait_got(1, 12);
    if (got.size() > 0) begin
      check("t4_data", got[0].d, 32'h2222_2222);
      check("t4_cycle", 32'(got[0].c), 32'(t0 + 2));
    end

    // Load in the same cycle as a read
    got.delete();
    load_en = 1;
    load_addr = 10'd2;
    load_data = 32'hDEAD_BEEF;
    req_valid = 1;
    req_addr = 32'h8;
    tick();
    load_en = 0;
    req_valid = 0;
    wait_got(1, 12);
    if (got.size() > 0)
      check("t5_old", got[0].d, 32'h3333_3333);
    got.delete();
    req_valid = 1;
    tick();
    req_valid = 0;
    wait_got(1, 12);
    if (got.size() > 0)
      check("t5_new", got[0].d, 32'hDEAD_BEEF);

    // Reset with two requests in flight
    got.delete();
    req_valid = 1;
    req_addr = 32'h0;
    tick();
    req_addr = 32'h4;
    tick();
    req_valid = 0;
    reset = 0;
    #1 check("t6_valid_async", 32'(resp_valid), 0);
    check("t6_ready_async", 32'(req_ready), 0);
    repeat (2) tick();
    reset = 1;
    tick();
    check("t6_ready_back", 32'(req_ready), 1);
    repeat (5) tick();
    check("t6_no_resp", 32'(got.size()), 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      if (r < 80)
        req_addr = 32'($urandom_range(0, 63) * 4);
      else if (r < 90)
        req_addr = 32'($urandom_range(0, 63) * 4
                 + $urandom_range(1, 3));
      else
        req_addr = 32'h1000 + $urandom_range(0, 4095);
      resp_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 99) < 3);
      load_en = ($urandom_range(0, 9) == 0);
      load_addr = 10'($urandom_range(0, 63));
      load_data = $urandom;
      tick();
    end
    req_valid = 0;
    flush = 0;
    load_en = 0;
    resp_ready = 1;
    repeat (10) tick();
    check("drain_empty", 32'(resp_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
